sfp_frame_tx_rx: RTL

- Framing stage between the MPS SFP control/register block and the Aurora/SFP AXI-Stream core.
- TX path: on a start pulse, serialises the C_DATA_FRAME_BIT-wide frame into C_TDATA_WIDTH beats, MSW first, then returns a TX-done pulse.
- RX path: reassembles incoming beats into a frame, presents it, and pulses an end flag.
- Malformed RX frames are dropped and counted.

---
 rtl/sfp_frame_tx_rx.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/sfp_frame_tx_rx.sv
// Frame serialiser/deserialiser between the SFP register block and an AXI-Stream link.
// Optional checksum beat on both paths: define SFP_FRAME_CHKSUM_EN.
module sfp_frame_tx_rx #(
   parameter int C_DATA_FRAME_BIT = 128,
   parameter int C_TDATA_WIDTH    = 32,
   parameter int C_RX_TIMEOUT     = 255
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [C_DATA_FRAME_BIT-1:0] i_tx_frame,
   input  logic                        i_sfp_start_flag,
   output logic                        o_tx_en,
   output logic                        o_tx_busy,
   output logic [C_TDATA_WIDTH-1:0]    m_axis_tdata,
   output logic                        m_axis_tvalid,
   output logic                        m_axis_tlast,
   input  logic                        m_axis_tready,
   input  logic [C_TDATA_WIDTH-1:0]    s_axis_tdata,
   input  logic                        s_axis_tvalid,
   input  logic                        s_axis_tlast,
   output logic [C_DATA_FRAME_BIT-1:0] o_rx_frame,
   output logic                        o_sfp_end_flag,
   output logic [15:0]                 o_rx_err_cnt
);

   localparam int FW = C_DATA_FRAME_BIT;
   localparam int DW = C_TDATA_WIDTH;
   localparam int NB = FW / DW;
`ifdef SFP_FRAME_CHKSUM_EN
   localparam int NBT = NB + 1;
`else
   localparam int NBT = NB;
`endif
   localparam int CW = $clog2(NBT + 1);
   localparam int GW = $clog2(C_RX_TIMEOUT + 1);

   typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_DONE} tx_st_e;
   typedef enum logic [1:0] {RX_IDLE, RX_COLLECT, RX_DROP} rx_st_e;

   tx_st_e          tx_st_q, tx_st_d;
   logic [FW-1:0]   tsh_q, tsh_d;
   logic [CW-1:0]   tcnt_q, tcnt_d;

   rx_st_e          rx_st_q, rx_st_d;
   logic [FW-1:0]   rsh_q, rsh_d, rsh_nx;
   logic [CW-1:0]   rcnt_q, rcnt_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [FW-1:0]   frame_q, frame_d;
   logic            end_q, end_d;
   logic [15:0]     err_q, err_d;
   logic            err_inc;

`ifdef SFP_FRAME_CHKSUM_EN
   logic [DW-1:0]   tsum_q, tsum_d;
   logic [DW-1:0]   rsum_q, rsum_d;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tx_st_q <= TX_IDLE;
         tsh_q   <= '0;
         tcnt_q  <= '0;
         rx_st_q <= RX_IDLE;
         rsh_q   <= '0;
         rcnt_q  <= '0;
         gap_q   <= '0;
         frame_q <= '0;
         end_q   <= 1'b0;
         err_q   <= '0;
`ifdef SFP_FRAME_CHKSUM_EN
         tsum_q  <= '0;
         rsum_q  <= '0;
`endif
      end else begin
         tx_st_q <= tx_st_d;
         tsh_q   <= tsh_d;
         tcnt_q  <= tcnt_d;
         rx_st_q <= rx_st_d;
         rsh_q   <= rsh_d;
         rcnt_q  <= rcnt_d;
         gap_q   <= gap_d;
         frame_q <= frame_d;
         end_q   <= end_d;
         err_q   <= err_d;
`ifdef SFP_FRAME_CHKSUM_EN
         tsum_q  <= tsum_d;
         rsum_q  <= rsum_d;
`endif
      end
   end

   always_comb begin
      tx_st_d       = tx_st_q;
      tsh_d         = tsh_q;
      tcnt_d        = tcnt_q;
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      o_tx_en       = 1'b0;
      o_tx_busy     = 1'b0;
`ifdef SFP_FRAME_CHKSUM_EN
      tsum_d        = tsum_q;
`endif
      unique case (tx_st_q)
         TX_IDLE: begin
            if (i_sfp_start_flag) begin
               tsh_d   = i_tx_frame;
               tcnt_d  = '0;
               tx_st_d = TX_SEND;
`ifdef SFP_FRAME_CHKSUM_EN
               tsum_d  = '0;
`endif
            end
         end
         TX_SEND: begin
            o_tx_busy     = 1'b1;
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = (tcnt_q == CW'(NBT - 1));
            m_axis_tdata  = tsh_q[FW-1 -: DW];
`ifdef SFP_FRAME_CHKSUM_EN
            if (tcnt_q == CW'(NB)) m_axis_tdata = tsum_q;
`endif
            if (m_axis_tready) begin
               tsh_d  = tsh_q << DW;
               tcnt_d = tcnt_q + CW'(1);
`ifdef SFP_FRAME_CHKSUM_EN
               tsum_d = tsum_q + tsh_q[FW-1 -: DW];
`endif
               if (m_axis_tlast) tx_st_d = TX_DONE;
            end
         end
         TX_DONE: begin
            o_tx_en = 1'b1;
            tx_st_d = TX_IDLE;
         end
         default: tx_st_d = TX_IDLE;
      endcase
   end

   always_comb begin
      rx_st_d = rx_st_q;
      rsh_d   = rsh_q;
      rcnt_d  = rcnt_q;
      gap_d   = gap_q;
      frame_d = frame_q;
      end_d   = 1'b0;
      err_inc = 1'b0;
      rsh_nx  = (rsh_q << DW) | FW'(s_axis_tdata);
`ifdef SFP_FRAME_CHKSUM_EN
      rsum_d  = rsum_q;
`endif
      unique case (rx_st_q)
         RX_IDLE: begin
            gap_d = '0;
            if (s_axis_tvalid) begin
               rsh_d  = FW'(s_axis_tdata);
               rcnt_d = CW'(1);
`ifdef SFP_FRAME_CHKSUM_EN
               rsum_d = s_axis_tdata;
`endif
               if (s_axis_tlast) begin
                  if (NBT == 1) begin
                     frame_d = FW'(s_axis_tdata);
                     end_d   = 1'b1;
                  end else begin
                     err_inc = 1'b1;
                  end
               end else if (NBT == 1) begin
                  err_inc = 1'b1;
                  rx_st_d = RX_DROP;
               end else begin
                  rx_st_d = RX_COLLECT;
               end
            end
         end
         RX_COLLECT: begin
            if (s_axis_tvalid) begin
               gap_d = '0;
               if (rcnt_q == CW'(NBT - 1)) begin
                  rx_st_d = RX_IDLE;
                  if (!s_axis_tlast) begin
                     err_inc = 1'b1;
                     rx_st_d = RX_DROP;
                  end else begin
`ifdef SFP_FRAME_CHKSUM_EN
                     if (s_axis_tdata != rsum_q) begin
                        err_inc = 1'b1;
                     end else begin
                        frame_d = rsh_q;
                        end_d   = 1'b1;
                     end
`else
                     frame_d = rsh_nx;
                     end_d   = 1'b1;
`endif
                  end
               end else if (s_axis_tlast) begin
                  err_inc = 1'b1;
                  rx_st_d = RX_IDLE;
               end else begin
                  rsh_d  = rsh_nx;
                  rcnt_d = rcnt_q + CW'(1);
`ifdef SFP_FRAME_CHKSUM_EN
                  rsum_d = rsum_q + s_axis_tdata;
`endif
               end
            end else if (gap_q == GW'(C_RX_TIMEOUT - 1)) begin
               err_inc = 1'b1;
               gap_d   = '0;
               rx_st_d = RX_IDLE;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         RX_DROP: begin
            if (s_axis_tvalid) begin
               gap_d = '0;
               if (s_axis_tlast) rx_st_d = RX_IDLE;
            end else if (gap_q == GW'(C_RX_TIMEOUT - 1)) begin
               gap_d   = '0;
               rx_st_d = RX_IDLE;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: rx_st_d = RX_IDLE;
      endcase
      err_d = (err_inc && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
   end

   assign o_rx_frame     = frame_q;
   assign o_sfp_end_flag = end_q;
   assign o_rx_err_cnt   = err_q;

endmodule
